pixel_window_mem: RTL and testbench
===================================

# pixel_window_mem

Parametrised, loadable pixel-window memory for the FAST9 corner pipeline. It replaces the fixed 6x6 test-pattern store with a two-bank (ping-pong) buffer. Each bank is filled one pixel at a time over a valid/ready write port, and a full window is served as one packed vector on a read request. It sits between the pixel streamer and the FAST9 comparator matrix, so one window can load while the previous one is being consumed.

## Interface
- PIX_W, 8: bits per pixel
- WIN, 6: window side length; window holds NPIX = WIN*WIN pixels
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- wrValid  input  1  write pixel offered
- wrPixel  input  PIX_W  pixel value, raster order (row-major, top-left first)
- wrReady  output  1  write accepted when wrValid & wrReady
- matReaden  input  1  read request (single-cycle pulse or level; sampled every cycle)
- matValid  output  1  one-cycle pulse: dbValue updated with a new window
- matMiss  output  1  one-cycle pulse: matReaden seen with no full bank
- dbValue  output  PIX_W*NPIX  packed window; pixel k (0-based raster) at dbValue[k*PIX_W +: PIX_W]
- fullCount  output  2  number of full banks (0..2)

## Operation
- Two banks, each EMPTY or FULL. Write pointer wrBank and index wrIdx (0..NPIX-1). Read pointer rdBank.
- Reset values: wrBank=0, rdBank=0, wrIdx=0, both banks EMPTY, wrReady=1, matValid=0, matMiss=0, dbValue=0, fullCount=0.
- Write:
  - wrReady = (bank[wrBank] is EMPTY).
  - An accepted pixel is stored at bank[wrBank][wrIdx] and wrIdx increments.
  - On the accept with wrIdx=NPIX-1: wrIdx wraps to 0, bank[wrBank] becomes FULL, and wrBank toggles.
- Read:
  - If matReaden=1 and bank[rdBank] is FULL at the clock edge: dbValue is loaded with bank[rdBank], matValid pulses, bank[rdBank] becomes EMPTY, and rdBank toggles.
  - If matReaden=1 and bank[rdBank] is EMPTY: matMiss pulses, and dbValue and matValid=0 are unchanged.
  - A held matReaden level serves one window per cycle while full banks exist.
- dbValue holds the last served window until the next serve; it never shows a partially filled bank.
- Banks are served strictly in fill order.
- fullCount equals the number of FULL banks and is registered.

## Timing
- Write: one pixel per cycle maximum. A window takes NPIX accepted cycles to fill.
- Read latency: matReaden sampled at edge N gives dbValue/matValid valid after edge N (visible in cycle N+1).
- Completing a fill and serving a read in the same cycle:
  - The read sees bank state from before the edge.
  - A bank that completes at edge N is servable from edge N+1.
  - Serving one bank and completing the other in the same cycle is legal, and fullCount is unchanged.
- A freed bank reasserts wrReady in the cycle after the serve edge.
- Back-pressure: with both banks FULL, wrReady=0 until a serve.
- Reset mid-fill or mid-serve: all state returns to its reset value immediately (asynchronous). Partial pixels are discarded.

## Structure
- Shared package fast9_pkg:
  - PIX_W / WIN defaults.
  - NPIX function.
  - bank_state_t enum {BANK_EMPTY, BANK_FULL}.
  - Index width constant $clog2(NPIX).
- Sub-module pixel_bank, instantiated twice:
  - NPIX x PIX_W register array with an indexed write (en, idx, data).
  - Continuously exposes the packed vector.
  - No reset on storage; it is only read once FULL.
- Top level holds the pointers, bank states, output register and miss/valid pulses.

## Test plan
- Fill and serve: write 36 pixels in this order: four 95, four 0, four 95, two 159, two 255, four 159, two 255, two 159, four 95, four 0, four 95. Then pulse matReaden.
  - Next cycle: matValid=1, dbValue[7:0]=95, dbValue[39:32]=0, dbValue[119:112]=255, dbValue[287:280]=95, fullCount back to 0.
- Back-pressure: stream 80 pixels with wrValid held and no reads.
  - wrReady drops after the 72nd accept; fullCount=2.
  - One matReaden: wrReady returns next cycle; pixel 73 is accepted.
- Miss: matReaden with no full bank gives matMiss=1 for one cycle, matValid=0 and dbValue unchanged.
- Ordering and simultaneity: fill window A (all 8'd1) and start window B (all 8'd2). Assert matReaden on the cycle B's 36th pixel is accepted.
  - dbValue shows all 1s.
  - fullCount stays 1.
  - The next read returns all 2s.
- Reset mid-fill: after 20 accepted pixels, pulse rst.
  - Outputs return to reset values (dbValue=0, wrReady=1).
  - Then write 36 pixels of value k (k=0..35) and read: dbValue[k*8 +: 8]=k for all k.
- Parameter sweep: WIN=3, PIX_W=10. A fill of 9 pixels sets fullCount=1 and the packed width is 90.

Source files
------------

// File: rtl/fast9_pkg.sv
// Shared types and sizing helpers for the FAST9 corner pipeline.
package fast9_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned WIN_DEF   = 6;

  function automatic int unsigned npix(input int unsigned win);
    return win * win;
  endfunction

  localparam int unsigned IDX_W_DEF = $clog2(WIN_DEF * WIN_DEF);

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

endpackage

// File: rtl/pixel_bank.sv
// One window of pixel storage with an indexed write port and a packed view.
module pixel_bank #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 36,
  parameter int unsigned IDX_W = 6
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [PIX_W-1:0]        data_i,
  output logic [PIX_W*NPIX-1:0]   vec_o
);

  logic [PIX_W*NPIX-1:0] mem_q;

  // Storage is never reset: a bank is only read after every slot was written.
  for (genvar k = 0; k < NPIX; k++) begin : g_pix
    always_ff @(posedge clk) begin
      if (en_i && (idx_i == IDX_W'(k))) begin
        mem_q[k*PIX_W +: PIX_W] <= data_i;
      end
    end
  end

  assign vec_o = mem_q;

endmodule

// File: rtl/pixel_window_mem.sv
// Ping-pong pixel-window buffer: raster pixel writes in, whole windows out.
module pixel_window_mem
  import fast9_pkg::*;
#(
  parameter int unsigned PIX_W = PIX_W_DEF,
  parameter int unsigned WIN   = WIN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wrValid,
  input  logic [PIX_W-1:0]            wrPixel,
  output logic                        wrReady,
  input  logic                        matReaden,
  output logic                        matValid,
  output logic                        matMiss,
  output logic [PIX_W*WIN*WIN-1:0]    dbValue,
  output logic [1:0]                  fullCount
);

  localparam int unsigned NPIX  = npix(WIN);
  localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned VEC_W = PIX_W * NPIX;

  logic              wrBank_q, wrBank_d;
  logic              rdBank_q, rdBank_d;
  logic [IDX_W-1:0]  wrIdx_q, wrIdx_d;
  bank_state_t       bank0_q, bank0_d;
  bank_state_t       bank1_q, bank1_d;
  logic [VEC_W-1:0]  dbValue_q, dbValue_d;
  logic              matValid_q, matValid_d;
  logic              matMiss_q, matMiss_d;
  logic [1:0]        fullCount_q, fullCount_d;

  logic              wrAcc, wrLast, rdHit;
  logic [VEC_W-1:0]  vec0, vec1;

  pixel_bank #(.PIX_W(PIX_W), .NPIX(NPIX), .IDX_W(IDX_W)) u_bank0 (
    .clk    (clk),
    .en_i   (wrAcc && !wrBank_q),
    .idx_i  (wrIdx_q),
    .data_i (wrPixel),
    .vec_o  (vec0)
  );

  pixel_bank #(.PIX_W(PIX_W), .NPIX(NPIX), .IDX_W(IDX_W)) u_bank1 (
    .clk    (clk),
    .en_i   (wrAcc && wrBank_q),
    .idx_i  (wrIdx_q),
    .data_i (wrPixel),
    .vec_o  (vec1)
  );

  always_comb begin
    wrReady = wrBank_q ? (bank1_q == BANK_EMPTY) : (bank0_q == BANK_EMPTY);
    wrAcc   = wrValid && wrReady;
    wrLast  = (wrIdx_q == IDX_W'(NPIX - 1));
    rdHit   = matReaden && (rdBank_q ? (bank1_q == BANK_FULL) : (bank0_q == BANK_FULL));
  end

  // Write completion and read serve always touch different banks (one must be
  // EMPTY, the other FULL), so both updates can apply in the same cycle.
  always_comb begin
    wrBank_d   = wrBank_q;
    rdBank_d   = rdBank_q;
    wrIdx_d    = wrIdx_q;
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    dbValue_d  = dbValue_q;
    matValid_d = 1'b0;
    matMiss_d  = 1'b0;

    if (wrAcc) begin
      if (wrLast) begin
        wrIdx_d  = '0;
        wrBank_d = ~wrBank_q;
        if (wrBank_q) bank1_d = BANK_FULL;
        else          bank0_d = BANK_FULL;
      end else begin
        wrIdx_d = wrIdx_q + 1'b1;
      end
    end

    if (matReaden) begin
      if (rdHit) begin
        dbValue_d  = rdBank_q ? vec1 : vec0;
        matValid_d = 1'b1;
        rdBank_d   = ~rdBank_q;
        if (rdBank_q) bank1_d = BANK_EMPTY;
        else          bank0_d = BANK_EMPTY;
      end else begin
        matMiss_d = 1'b1;
      end
    end

    fullCount_d = {1'b0, bank0_d == BANK_FULL} + {1'b0, bank1_d == BANK_FULL};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrBank_q    <= 1'b0;
      rdBank_q    <= 1'b0;
      wrIdx_q     <= '0;
      bank0_q     <= BANK_EMPTY;
      bank1_q     <= BANK_EMPTY;
      dbValue_q   <= '0;
      matValid_q  <= 1'b0;
      matMiss_q   <= 1'b0;
      fullCount_q <= '0;
    end else begin
      wrBank_q    <= wrBank_d;
      rdBank_q    <= rdBank_d;
      wrIdx_q     <= wrIdx_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      dbValue_q   <= dbValue_d;
      matValid_q  <= matValid_d;
      matMiss_q   <= matMiss_d;
      fullCount_q <= fullCount_d;
    end
  end

  assign dbValue   = dbValue_q;
  assign matValid  = matValid_q;
  assign matMiss   = matMiss_q;
  assign fullCount = fullCount_q;

endmodule

// File: tb/tb_pixel_window_mem.sv
// Directed bench for pixel_window_mem (default 6x6x8 plus a 3x3x10 instance).
module tb_pixel_window_mem;

  logic         clk = 1'b0;
  logic         rst;
  logic         wrValid, matReaden;
  logic [7:0]   wrPixel;
  logic         wrReady, matValid, matMiss;
  logic [287:0] dbValue;
  logic [1:0]   fullCount;

  logic         wrValid_s, matReaden_s;
  logic [9:0]   wrPixel_s;
  logic         wrReady_s, matValid_s, matMiss_s;
  logic [89:0]  dbValue_s;
  logic [1:0]   fullCount_s;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;

  always #5 clk = ~clk;

  pixel_window_mem u_dut (
    .clk(clk), .rst(rst),
    .wrValid(wrValid), .wrPixel(wrPixel), .wrReady(wrReady),
    .matReaden(matReaden), .matValid(matValid), .matMiss(matMiss),
    .dbValue(dbValue), .fullCount(fullCount)
  );

  pixel_window_mem #(.PIX_W(10), .WIN(3)) u_small (
    .clk(clk), .rst(rst),
    .wrValid(wrValid_s), .wrPixel(wrPixel_s), .wrReady(wrReady_s),
    .matReaden(matReaden_s), .matValid(matValid_s), .matMiss(matMiss_s),
    .dbValue(dbValue_s), .fullCount(fullCount_s)
  );

  task automatic check_eq(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the pixel was accepted.
  task automatic push(input logic [7:0] p);
    int unsigned n = 0;
    wrValid = 1'b1;
    wrPixel = p;
    while (!wrReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!wrReady) check_eq("push_timeout", {287'd0, wrReady}, 288'd1);
    @(negedge clk);
    wrValid = 1'b0;
  endtask

  task automatic rd();
    matReaden = 1'b1;
    @(negedge clk);
    matReaden = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0]   pat [36];
  logic [287:0] exp_pat, exp_ones, exp_twos, exp_ramp;
  logic [89:0]  exp_small;
  int unsigned  cnt;
  logic         acc;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wrValid = 1'b0; wrPixel = '0; matReaden = 1'b0;
    wrValid_s = 1'b0; wrPixel_s = '0; matReaden_s = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_wrReady", {287'd0, wrReady}, 288'd1);
    check_eq("rst_matValid", {287'd0, matValid}, 288'd0);
    check_eq("rst_matMiss", {287'd0, matMiss}, 288'd0);
    check_eq("rst_dbValue", dbValue, 288'd0);
    check_eq("rst_fullCount", {286'd0, fullCount}, 288'd0);

    // Fill and serve the test pattern
    for (int i = 0;  i < 4;  i++) pat[i] = 8'd95;
    for (int i = 4;  i < 8;  i++) pat[i] = 8'd0;
    for (int i = 8;  i < 12; i++) pat[i] = 8'd95;
    for (int i = 12; i < 14; i++) pat[i] = 8'd159;
    for (int i = 14; i < 16; i++) pat[i] = 8'd255;
    for (int i = 16; i < 20; i++) pat[i] = 8'd159;
    for (int i = 20; i < 22; i++) pat[i] = 8'd255;
    for (int i = 22; i < 24; i++) pat[i] = 8'd159;
    for (int i = 24; i < 28; i++) pat[i] = 8'd95;
    for (int i = 28; i < 32; i++) pat[i] = 8'd0;
    for (int i = 32; i < 36; i++) pat[i] = 8'd95;
    for (int i = 0; i < 36; i++) exp_pat[i*8 +: 8] = pat[i];
    for (int i = 0; i < 36; i++) push(pat[i]);
    check_eq("fill_fullCount1", {286'd0, fullCount}, 288'd1);
    check_eq("fill_noValid", {287'd0, matValid}, 288'd0);
    rd();
    check_eq("serve_matValid", {287'd0, matValid}, 288'd1);
    check_eq("serve_pix0", {280'd0, dbValue[7:0]}, 288'd95);
    check_eq("serve_pix4", {280'd0, dbValue[39:32]}, 288'd0);
    check_eq("serve_pix14", {280'd0, dbValue[119:112]}, 288'd255);
    check_eq("serve_pix35", {280'd0, dbValue[287:280]}, 288'd95);
    check_eq("serve_window", dbValue, exp_pat);
    check_eq("serve_fullCount0", {286'd0, fullCount}, 288'd0);
    @(negedge clk);
    check_eq("serve_pulse_end", {287'd0, matValid}, 288'd0);

    // Miss with no full bank
    rd();
    check_eq("miss_matMiss", {287'd0, matMiss}, 288'd1);
    check_eq("miss_matValid", {287'd0, matValid}, 288'd0);
    check_eq("miss_dbValue", dbValue, exp_pat);
    @(negedge clk);
    check_eq("miss_pulse_end", {287'd0, matMiss}, 288'd0);

    // Back-pressure with wrValid held
    do_reset();
    cnt = 0;
    wrValid = 1'b1;
    for (int c = 0; c < 100 && cnt < 72; c++) begin
      wrPixel = cnt[7:0];
      acc = wrReady;
      @(negedge clk);
      if (acc) cnt++;
    end
    check_eq("bp_accepts", 288'(cnt), 288'd72);
    check_eq("bp_wrReady0", {287'd0, wrReady}, 288'd0);
    check_eq("bp_fullCount2", {286'd0, fullCount}, 288'd2);
    wrPixel = 8'd72;
    @(negedge clk);
    check_eq("bp_still_blocked", {287'd0, wrReady}, 288'd0);
    rd();
    check_eq("bp_serve_valid", {287'd0, matValid}, 288'd1);
    check_eq("bp_wrReady_back", {287'd0, wrReady}, 288'd1);
    check_eq("bp_serve_pix0", {280'd0, dbValue[7:0]}, 288'd0);
    check_eq("bp_serve_pix35", {280'd0, dbValue[287:280]}, 288'd35);
    @(negedge clk);
    wrValid = 1'b0;
    check_eq("bp_fullCount1", {286'd0, fullCount}, 288'd1);
    for (int i = 0; i < 35; i++) push(8'(73 + i));
    rd();
    check_eq("bp_second_pix0", {280'd0, dbValue[7:0]}, 288'd36);
    rd();
    check_eq("bp_third_pix0", {280'd0, dbValue[7:0]}, 288'd72);
    check_eq("bp_third_pix1", {280'd0, dbValue[15:8]}, 288'd73);
    check_eq("bp_fullCount_end", {286'd0, fullCount}, 288'd0);

    // Serve A while B completes in the same cycle
    do_reset();
    for (int i = 0; i < 36; i++) exp_ones[i*8 +: 8] = 8'd1;
    for (int i = 0; i < 36; i++) exp_twos[i*8 +: 8] = 8'd2;
    for (int i = 0; i < 36; i++) push(8'd1);
    for (int i = 0; i < 35; i++) push(8'd2);
    check_eq("sim_ready", {287'd0, wrReady}, 288'd1);
    wrValid = 1'b1; wrPixel = 8'd2; matReaden = 1'b1;
    @(negedge clk);
    wrValid = 1'b0; matReaden = 1'b0;
    check_eq("sim_valid", {287'd0, matValid}, 288'd1);
    check_eq("sim_window_A", dbValue, exp_ones);
    check_eq("sim_fullCount", {286'd0, fullCount}, 288'd1);
    rd();
    check_eq("sim_window_B", dbValue, exp_twos);
    check_eq("sim_fullCount0", {286'd0, fullCount}, 288'd0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 20; i++) push(8'd9);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_dbValue", dbValue, 288'd0);
    check_eq("arst_wrReady", {287'd0, wrReady}, 288'd1);
    check_eq("arst_fullCount", {286'd0, fullCount}, 288'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) exp_ramp[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 36; i++) push(8'(i));
    rd();
    check_eq("arst_ramp_valid", {287'd0, matValid}, 288'd1);
    check_eq("arst_ramp_window", dbValue, exp_ramp);

    // Small instance: WIN=3, PIX_W=10
    for (int i = 0; i < 9; i++) exp_small[i*10 +: 10] = 10'(i * 100 + 7);
    check_eq("small_ready", {287'd0, wrReady_s}, 288'd1);
    wrValid_s = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wrPixel_s = 10'(i * 100 + 7);
      @(negedge clk);
    end
    wrValid_s = 1'b0;
    check_eq("small_fullCount1", {286'd0, fullCount_s}, 288'd1);
    matReaden_s = 1'b1;
    @(negedge clk);
    matReaden_s = 1'b0;
    check_eq("small_valid", {287'd0, matValid_s}, 288'd1);
    check_eq("small_window", {198'd0, dbValue_s}, {198'd0, exp_small});
    check_eq("small_fullCount0", {286'd0, fullCount_s}, 288'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
